// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the two-road traffic light controller.
// C1/C3 encodings exist always; they are only reachable with TRAFFIC_ALLRED_EN defined.
package traffic_light_pkg;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      C1 = 3'd4,
      C3 = 3'd5
   } state_t;

   // Words are right-justified in 64 bits with zero upper bytes.
   localparam logic [63:0] LIGHT_GREEN  = {24'h0, "GREEN"};
   localparam logic [63:0] LIGHT_YELLOW = {16'h0, "YELLOW"};
   localparam logic [63:0] LIGHT_RED    = {40'h0, "RED"};

   // States whose duration is set by the dwell counter rather than by sensors.
   function automatic logic is_timed(input state_t s);
      return (s == S1) || (s == S3) || (s == C1) || (s == C3);
   endfunction

endpackage

// File: rtl/traffic_light_mode.sv
// Parade mode register: p sets, r clears, p wins when both are high.
module traffic_light_mode (
   input  logic clk,
   input  logic rstn,
   input  logic p,
   input  logic r,
   output logic m
);

   always_ff @(posedge clk) begin
      if (rstn) begin
         m <= 1'b0;
      end else if (p) begin
         m <= 1'b1;
      end else if (r) begin
         m <= 1'b0;
      end
   end

endmodule

// File: rtl/traffic_light.sv
// Two-road Moore traffic light controller with sensor hold and parade mode.
// Optional all-red clearance phases are enabled by defining TRAFFIC_ALLRED_EN.
module traffic_light
   import traffic_light_pkg::*;
#(
   parameter int YELLOW_CYCLES = 5,
   parameter int ALLRED_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        p,
   input  logic        r,
   input  logic        t_a,
   input  logic        t_b,
   output logic [63:0] l_a,
   output logic [63:0] l_b
);

   localparam int CNT_MAX = (YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYCLES - 1);
`ifdef TRAFFIC_ALLRED_EN
   localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_CYCLES - 1);
`endif

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             m;

   traffic_light_mode u_mode (
      .clk  (clk),
      .rstn (rstn),
      .p    (p),
      .r    (r),
      .m    (m)
   );

   always_ff @(posedge clk) begin
      if (rstn) begin
         state <= S0;
      end else begin
         state <= state_nxt;
      end
   end

   // Counter restarts on every state change so each timed phase sees 0..LAST.
   always_ff @(posedge clk) begin
      if (rstn || (state_nxt != state)) begin
         cnt <= '0;
      end else if (is_timed(state)) begin
         cnt <= cnt + CNT_W'(1);
      end else begin
         cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = S0;
      case (state)
         S0: state_nxt = t_a ? S0 : S1;
`ifdef TRAFFIC_ALLRED_EN
         S1: state_nxt = (cnt == Y_LAST) ? C1 : S1;
         C1: state_nxt = (cnt == A_LAST) ? S2 : C1;
         S2: state_nxt = (!t_b && !m) ? S3 : S2;
         S3: state_nxt = (cnt == Y_LAST) ? C3 : S3;
         C3: state_nxt = (cnt == A_LAST) ? S0 : C3;
`else
         S1: state_nxt = (cnt == Y_LAST) ? S2 : S1;
         S2: state_nxt = (!t_b && !m) ? S3 : S2;
         S3: state_nxt = (cnt == Y_LAST) ? S0 : S3;
`endif
         default: state_nxt = S0;
      endcase
   end

   // Any state without a light assignment shows red on both roads.
   always_comb begin
      l_a = LIGHT_RED;
      l_b = LIGHT_RED;
      case (state)
         S0: begin l_a = LIGHT_GREEN;  l_b = LIGHT_RED;    end
         S1: begin l_a = LIGHT_YELLOW; l_b = LIGHT_RED;    end
         S2: begin l_a = LIGHT_RED;    l_b = LIGHT_GREEN;  end
         S3: begin l_a = LIGHT_RED;    l_b = LIGHT_YELLOW; end
         default: begin l_a = LIGHT_RED; l_b = LIGHT_RED;  end
      endcase
   end

endmodule

// File: tb/tb_traffic_light.sv
// Scoreboard bench for traffic_light: stimulus pushes expected lights, a monitor pops and compares.
// Expectations follow TRAFFIC_ALLRED_EN when the bench is built with it defined.
module tb_traffic_light;

   localparam logic [63:0] G = {24'h0, "GREEN"};
   localparam logic [63:0] Y = {16'h0, "YELLOW"};
   localparam logic [63:0] R = {40'h0, "RED"};

   logic        clk = 1'b0;
   logic        rstn;
   logic        p;
   logic        r;
   logic        t_a;
   logic        t_b;
   logic [63:0] l_a;
   logic [63:0] l_b;

   logic [127:0] exp_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic         rst_req  = 1'b1;
   string        phase    = "reset";

   // model state for the random phase: 0=S0 1=S1 2=S2 3=S3 4=C1 5=C3
   int   md_ph  = 0;
   int   md_rem = 0;
   logic md_m   = 1'b0;

   traffic_light #(.YELLOW_CYCLES(5), .ALLRED_CYCLES(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .p    (p),
      .r    (r),
      .t_a  (t_a),
      .t_b  (t_b),
      .l_a  (l_a),
      .l_b  (l_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin : monitor
      logic [127:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if ({l_a, l_b} !== e) begin
            n_fail++;
            $display("FAIL lights[%s] t=%0t: l_a=%h l_b=%h expected l_a=%h l_b=%h",
                     phase, $time, l_a, l_b, e[127:64], e[63:0]);
         end
      end
   end

   task automatic cyc(input logic pp, input logic rr, input logic ta, input logic tb,
                      input logic [63:0] ea, input logic [63:0] eb);
      @(negedge clk);
      rstn = rst_req;
      p    = pp;
      r    = rr;
      t_a  = ta;
      t_b  = tb;
      exp_q.push_back({ea, eb});
   endtask

   task automatic rep(input int n, input logic pp, input logic rr, input logic ta, input logic tb,
                      input logic [63:0] ea, input logic [63:0] eb);
      for (int i = 0; i < n; i++) cyc(pp, rr, ta, tb, ea, eb);
   endtask

   task automatic allred(input logic ta, input logic tb);
`ifdef TRAFFIC_ALLRED_EN
      rep(2, 1'b0, 1'b0, ta, tb, R, R);
`else
      if (ta === 1'bx || tb === 1'bx) $display("note: unknown sensor value");
`endif
   endtask

   task automatic full_cycle();
      rep(5, 0, 0, 0, 0, Y, R);
      allred(0, 0);
      cyc(0, 0, 0, 0, R, G);
      rep(5, 0, 0, 0, 0, R, Y);
      allred(0, 0);
      cyc(0, 0, 0, 0, G, R);
   endtask

   task automatic model_step(input logic pp, input logic rr, input logic ta, input logic tb,
                             output logic [63:0] ea, output logic [63:0] eb);
      case (md_ph)
         0: if (!ta) begin md_ph = 1; md_rem = 5; end
         1: if (md_rem == 1) begin
`ifdef TRAFFIC_ALLRED_EN
               md_ph = 4; md_rem = 2;
`else
               md_ph = 2;
`endif
            end else md_rem--;
         4: if (md_rem == 1) md_ph = 2; else md_rem--;
         2: if (!tb && !md_m) begin md_ph = 3; md_rem = 5; end
         3: if (md_rem == 1) begin
`ifdef TRAFFIC_ALLRED_EN
               md_ph = 5; md_rem = 2;
`else
               md_ph = 0;
`endif
            end else md_rem--;
         5: if (md_rem == 1) md_ph = 0; else md_rem--;
         default: md_ph = 0;
      endcase
      md_m = pp ? 1'b1 : (rr ? 1'b0 : md_m);
      case (md_ph)
         0:       begin ea = G; eb = R; end
         1:       begin ea = Y; eb = R; end
         2:       begin ea = R; eb = G; end
         3:       begin ea = R; eb = Y; end
         default: begin ea = R; eb = R; end
      endcase
   endtask

   initial begin
      logic [63:0] ea, eb;
      logic        pp, rr, ta, tb;
      rstn = 1'b1;
      p    = 1'b0;
      r    = 1'b0;
      t_a  = 1'b0;
      t_b  = 1'b0;

      phase = "reset";
      rep(20, 0, 0, 0, 0, G, R);

      phase = "full_cycle";
      rst_req = 1'b0;
      full_cycle();
      full_cycle();

      phase = "sensor_hold";
      rep(100, 0, 0, 1, 0, G, R);
      rep(5, 0, 0, 0, 1, Y, R);
      allred(0, 1);
      rep(20, 0, 0, 0, 1, R, G);
      cyc(0, 0, 1, 0, R, Y);
      rep(4, 0, 0, 1, 0, R, Y);
      allred(1, 0);
      rep(2, 0, 0, 1, 0, G, R);

      phase = "parade";
      cyc(1, 0, 1, 0, G, R);
      rep(5, 0, 0, 0, 0, Y, R);
      allred(0, 0);
      rep(30, 0, 0, 0, 0, R, G);
      cyc(0, 1, 0, 0, R, G);
      rep(5, 0, 0, 1, 0, R, Y);
      allred(1, 0);
      rep(2, 0, 0, 1, 0, G, R);

      phase = "p_and_r";
      cyc(1, 1, 1, 0, G, R);
      rep(5, 0, 0, 0, 0, Y, R);
      allred(0, 0);
      rep(3, 0, 0, 0, 0, R, G);
      cyc(0, 1, 0, 0, R, G);
      rep(5, 0, 0, 1, 0, R, Y);
      allred(1, 0);
      rep(2, 0, 0, 1, 0, G, R);

      phase = "reset_clears_mode";
      cyc(1, 0, 1, 0, G, R);
      rst_req = 1'b1;
      cyc(0, 0, 1, 0, G, R);
      rst_req = 1'b0;
      rep(5, 0, 0, 0, 0, Y, R);
      allred(0, 0);
      cyc(0, 0, 0, 0, R, G);
      rep(5, 0, 0, 1, 0, R, Y);
      allred(1, 0);
      rep(2, 0, 0, 1, 0, G, R);

      phase = "reset_mid_yellow";
      rep(2, 0, 0, 0, 0, Y, R);
      rst_req = 1'b1;
      cyc(0, 0, 0, 0, G, R);
      rst_req = 1'b0;
      rep(3, 0, 0, 1, 0, G, R);

      phase = "random";
      md_ph  = 0;
      md_rem = 0;
      md_m   = 1'b0;
      for (int i = 0; i < 150; i++) begin
         pp = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         ta = 1'($urandom_range(0, 1));
         tb = 1'($urandom_range(0, 1));
         model_step(pp, rr, ta, tb, ea, eb);
         cyc(pp, rr, ta, tb, ea, eb);
      end

      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
